// File: rtl/qea_run_pkg.sv
// Shared parameters, FSM encoding and helpers for the QEA run controller.
package qea_run_pkg;

  localparam int unsigned PE_NUM_WIDTH            = 2;
  localparam int unsigned PE_NUM                  = 4;
  localparam int unsigned DATA_WIDTH              = 32;
  localparam int unsigned STATE_DATA_WIDTH        = 64;
  localparam int unsigned STATE_ADDR_WIDTH        = 16;
  localparam int unsigned GATE_CONTEXT_DATA_WIDTH = 64;
  localparam int unsigned GATE_CONTEXT_ADDR_WIDTH = 16;
  localparam int unsigned MAX_QBIT_WIDTH          = 6;
  localparam int unsigned NUM_FRAC_BIT            = 30;
  localparam int unsigned STATE_RD_LATENCY        = 2;
  localparam int unsigned CYC_CNT_WIDTH           = 32;

  localparam int unsigned WORD_W = PE_NUM * STATE_DATA_WIDTH;
  localparam int unsigned WCNT_W = STATE_ADDR_WIDTH + 1;
  localparam int unsigned INS_W  = GATE_CONTEXT_ADDR_WIDTH + 1;
  localparam int unsigned CNT_W  = (INS_W > WCNT_W) ? INS_W : WCNT_W;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LD_CTX, ST_LD_STATE, ST_START, ST_RUN, ST_READ, ST_DONE
  } run_state_e;

  // |0..0>: amplitude 1.0 in the real half of the top PE slot of word 0
  localparam logic [DATA_WIDTH-1:0] INIT_REAL = DATA_WIDTH'(1) << NUM_FRAC_BIT;
  localparam logic [WORD_W-1:0]     INIT_WORD = {INIT_REAL, {(WORD_W - DATA_WIDTH){1'b0}}};

  typedef struct packed {
    logic              err;
    logic [WCNT_W-1:0] words;
  } word_cnt_t;

  // State words for a qubit count; err when the vector exceeds the state RAM
  function automatic word_cnt_t calc_words(input logic [MAX_QBIT_WIDTH-1:0] qbit);
    word_cnt_t                 r;
    logic [MAX_QBIT_WIDTH-1:0] sh;
    r.err   = 1'b0;
    r.words = WCNT_W'(1);
    sh      = '0;
    if (qbit > MAX_QBIT_WIDTH'(PE_NUM_WIDTH)) begin
      sh = qbit - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
      if (sh > MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH)) r.err = 1'b1;
      else r.words = WCNT_W'(1) << sh;
    end
    return r;
  endfunction

endpackage

// File: rtl/qea_run_rd_pipe.sv
// Readback pipe: tracks an issued state-RAM read through its latency, then holds
// the word with valid until the consumer accepts it.
module qea_run_rd_pipe
  import qea_run_pkg::*;
#(
  parameter int unsigned LAT = STATE_RD_LATENCY,
  parameter int unsigned DW  = WORD_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_issue,
  input  logic          i_last,
  input  logic [DW-1:0] i_dout,
  input  logic          i_rd_ready,
  output logic          o_rd_valid,
  output logic [DW-1:0] o_rd_data,
  output logic          o_rd_last,
  output logic          o_hs_c
);

  logic [LAT-1:0] vld_sr_q, vld_sr_d, last_sr_q, last_sr_d;
  logic           valid_q, valid_d, last_q, last_d;
  logic [DW-1:0]  data_q, data_d;

  assign o_hs_c     = valid_q & i_rd_ready;
  assign o_rd_valid = valid_q;
  assign o_rd_data  = data_q;
  assign o_rd_last  = last_q;

  // Advance latency tags, capture returning data, drop valid on handshake
  always_comb begin
    vld_sr_d  = (vld_sr_q << 1) | LAT'(i_issue);
    last_sr_d = (last_sr_q << 1) | LAT'(i_issue & i_last);
    valid_d   = valid_q;
    data_d    = data_q;
    last_d    = last_q;
    if (o_hs_c) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
    if (vld_sr_q[LAT-1]) begin
      valid_d = 1'b1;
      data_d  = i_dout;
      last_d  = last_sr_q[LAT-1];
    end
    if (i_flush) begin
      vld_sr_d  = '0;
      last_sr_d = '0;
      valid_d   = 1'b0;
      last_d    = 1'b0;
    end
  end

  // Pipe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr_q  <= '0;
      last_sr_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
    end else begin
      vld_sr_q  <= vld_sr_d;
      last_sr_q <= last_sr_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      last_q    <= last_d;
    end
  end

endmodule

// File: rtl/qea_run_controller.sv
// QEA run sequencer: ctx load, state load, start, cycle count, readback.
// Optional QEA_AUTO_INIT_EN: controller writes the |0..0> state itself.
module qea_run_controller
  import qea_run_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_run,
  input  logic                               i_abort,
  input  logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num,
  input  logic [INS_W-1:0]                   i_ins_num,
  input  logic                               i_auto_init,
  input  logic                               i_ld_valid,
  output logic                               o_ld_ready,
  input  logic [WORD_W-1:0]                  i_ld_data,
  output logic                               o_rd_valid,
  input  logic                               i_rd_ready,
  output logic [WORD_W-1:0]                  o_rd_data,
  output logic                               o_rd_last,
  output logic                               o_ctx_en,
  output logic                               o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0] o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0] o_ctx_data,
  output logic [PE_NUM-1:0]                  o_state_ena,
  output logic [PE_NUM-1:0]                  o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]        o_state_addra,
  output logic [WORD_W-1:0]                  o_state_dina,
  input  logic [WORD_W-1:0]                  i_state_dout,
  output logic                               o_start,
  output logic [MAX_QBIT_WIDTH-1:0]          o_qbit_num,
  input  logic                               i_complete,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_err,
  output logic [CYC_CNT_WIDTH-1:0]           o_exec_cycles
);

  run_state_e                state_q, state_d;
  logic [MAX_QBIT_WIDTH-1:0] qbit_q, qbit_d;
  logic [INS_W-1:0]          ins_q, ins_d;
  logic [WCNT_W-1:0]         words_q, words_d;
  logic                      err_q, err_d, outst_q, outst_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d, last_ins_c, last_word_c;
  logic [CYC_CNT_WIDTH-1:0]  exec_q, exec_d;
  word_cnt_t                 wc;
  logic                      run_acc_c, ld_fire_c, auto_c, rd_issue_c, rd_last_tag_c, rd_hs_c;

  assign run_acc_c   = i_run & ~i_abort & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign ld_fire_c   = i_ld_valid & o_ld_ready;
  assign last_ins_c  = CNT_W'(ins_q) - CNT_W'(1);
  assign last_word_c = CNT_W'(words_q) - CNT_W'(1);

`ifdef QEA_AUTO_INIT_EN
  logic auto_q, auto_d;
  assign auto_d = run_acc_c ? i_auto_init : auto_q;
  assign auto_c = auto_q;
  // Auto-init selection, latched with the run request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) auto_q <= 1'b0;
    else        auto_q <= auto_d;
  end
`else
  logic auto_init_unused;
  assign auto_init_unused = i_auto_init;
  assign auto_c           = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      qbit_q  <= '0;
      ins_q   <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
      outst_q <= 1'b0;
      cnt_q   <= '0;
      exec_q  <= '0;
    end else begin
      state_q <= state_d;
      qbit_q  <= qbit_d;
      ins_q   <= ins_d;
      words_q <= words_d;
      err_q   <= err_d;
      outst_q <= outst_d;
      cnt_q   <= cnt_d;
      exec_q  <= exec_d;
    end
  end

  // Next state, phase counters and execution cycle counter
  always_comb begin
    state_d = state_q;
    qbit_d  = qbit_q;
    ins_d   = ins_q;
    words_d = words_q;
    err_d   = err_q;
    outst_d = outst_q;
    cnt_d   = cnt_q;
    exec_d  = exec_q;
    wc      = '0;
    if (i_abort) begin
      state_d = ST_IDLE;
      err_d   = 1'b0;
      outst_d = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (i_run) begin
            wc      = calc_words(i_qbit_num);
            qbit_d  = i_qbit_num;
            ins_d   = i_ins_num;
            words_d = wc.words;
            err_d   = wc.err;
            cnt_d   = '0;
            if (wc.err)               state_d = ST_DONE;
            else if (i_ins_num == '0) state_d = ST_LD_STATE;
            else                      state_d = ST_LD_CTX;
          end
        end
        ST_LD_CTX: begin
          if (ld_fire_c) begin
            if (cnt_q == last_ins_c) begin
              cnt_d   = '0;
              state_d = ST_LD_STATE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_LD_STATE: begin
          if (o_state_wea[0]) begin
            if (cnt_q == last_word_c) begin
              cnt_d   = '0;
              state_d = ST_START;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_START: begin
          exec_d  = '0;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (exec_q != '1) exec_d = exec_q + CYC_CNT_WIDTH'(1);
          if (i_complete) begin
            cnt_d   = '0;
            state_d = ST_READ;
          end
        end
        ST_READ: begin
          if (rd_issue_c) outst_d = 1'b1;
          if (rd_hs_c) begin
            outst_d = 1'b0;
            if (o_rd_last) state_d = ST_DONE;
            else           cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Memory-port, handshake and start outputs decoded from the current phase
  always_comb begin
    o_ld_ready    = 1'b0;
    o_ctx_en      = 1'b0;
    o_ctx_wea     = 1'b0;
    o_ctx_addr    = '0;
    o_ctx_data    = '0;
    o_state_ena   = '0;
    o_state_wea   = '0;
    o_state_addra = '0;
    o_state_dina  = '0;
    o_start       = 1'b0;
    rd_issue_c    = 1'b0;
    rd_last_tag_c = 1'b0;
    case (state_q)
      ST_LD_CTX: begin
        o_ld_ready = ~i_abort;
        if (i_ld_valid && !i_abort) begin
          o_ctx_en   = 1'b1;
          o_ctx_wea  = 1'b1;
          o_ctx_addr = cnt_q[GATE_CONTEXT_ADDR_WIDTH-1:0];
          o_ctx_data = i_ld_data[GATE_CONTEXT_DATA_WIDTH-1:0];
        end
      end
      ST_LD_STATE: begin
        if (auto_c) begin
          if (!i_abort) begin
            o_state_ena   = '1;
            o_state_wea   = '1;
            o_state_addra = cnt_q[STATE_ADDR_WIDTH-1:0];
            o_state_dina  = (cnt_q == '0) ? INIT_WORD : '0;
          end
        end else begin
          o_ld_ready = ~i_abort;
          if (i_ld_valid && !i_abort) begin
            o_state_ena   = '1;
            o_state_wea   = '1;
            o_state_addra = cnt_q[STATE_ADDR_WIDTH-1:0];
            o_state_dina  = i_ld_data;
          end
        end
      end
      ST_START: o_start = ~i_abort;
      ST_READ: begin
        if (!i_abort) begin
          o_state_ena   = '1;
          o_state_addra = cnt_q[STATE_ADDR_WIDTH-1:0];
          rd_issue_c    = ~outst_q;
          rd_last_tag_c = (cnt_q == last_word_c);
        end
      end
      default: ;
    endcase
  end

  assign o_busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign o_done        = (state_q == ST_DONE);
  assign o_err         = err_q;
  assign o_qbit_num    = qbit_q;
  assign o_exec_cycles = exec_q;

  qea_run_rd_pipe #(.LAT(STATE_RD_LATENCY), .DW(WORD_W)) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_flush   (i_abort),
    .i_issue   (rd_issue_c),
    .i_last    (rd_last_tag_c),
    .i_dout    (i_state_dout),
    .i_rd_ready(i_rd_ready),
    .o_rd_valid(o_rd_valid),
    .o_rd_data (o_rd_data),
    .o_rd_last (o_rd_last),
    .o_hs_c    (rd_hs_c)
  );

endmodule

// File: tb/tb_qea_run_controller.sv
// Directed bench for qea_run_controller with a 2-cycle state RAM model and
// queue scoreboards for ctx writes, state writes and readback words.
module tb_qea_run_controller;
  import qea_run_pkg::*;

  localparam logic [255:0] INIT_EXP = {64'h4000_0000_0000_0000, 192'h0};

  logic                               clk = 1'b0;
  logic                               rst_n;
  logic                               i_run, i_abort, i_auto_init, i_ld_valid, i_rd_ready, i_complete;
  logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num;
  logic [INS_W-1:0]                   i_ins_num;
  logic [WORD_W-1:0]                  i_ld_data, i_state_dout;
  logic                               o_ld_ready, o_rd_valid, o_rd_last, o_ctx_en, o_ctx_wea;
  logic                               o_start, o_busy, o_done, o_err;
  logic [WORD_W-1:0]                  o_rd_data, o_state_dina;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] o_ctx_addr;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] o_ctx_data;
  logic [PE_NUM-1:0]                  o_state_ena, o_state_wea;
  logic [STATE_ADDR_WIDTH-1:0]        o_state_addra;
  logic [MAX_QBIT_WIDTH-1:0]          o_qbit_num;
  logic [CYC_CNT_WIDTH-1:0]           o_exec_cycles;

  always #5 clk = ~clk;

  qea_run_controller dut (
    .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_abort(i_abort),
    .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num), .i_auto_init(i_auto_init),
    .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready), .i_ld_data(i_ld_data),
    .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data), .o_rd_last(o_rd_last),
    .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
    .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
    .o_state_dina(o_state_dina), .i_state_dout(i_state_dout), .o_start(o_start),
    .o_qbit_num(o_qbit_num), .i_complete(i_complete), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_exec_cycles(o_exec_cycles)
  );

  int vec = 0, errs = 0;
  int ctx_wr_n, st_wr_n, rd_n, start_w, start_pulses, exp_words;
  logic [255:0] exp_ctx[$], exp_wr[$], exp_rd[$];
  logic         stall_pend = 1'b0;
  logic [255:0] stall_data;
  logic [255:0] mem [0:1023];
  logic [9:0]   ra;
  logic [255:0] w0, m0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // State RAM model: address registered, data registered one cycle later
  always @(posedge clk) begin
    if (o_state_wea != '0) mem[o_state_addra[9:0]] <= o_state_dina;
    ra           <= o_state_addra[9:0];
    i_state_dout <= mem[ra];
  end

  // Monitor: write ports, start pulse width, readback handshakes and stalls
  always @(negedge clk) begin
    if (o_ctx_en) begin
      chk("ctx_wea", 256'(o_ctx_wea), 256'(1));
      chk("ctx_addr", 256'(o_ctx_addr), 256'(ctx_wr_n));
      if (exp_ctx.size() == 0) chk("ctx_unexpected", 256'(exp_ctx.size()), 256'(1));
      else chk("ctx_data", 256'(o_ctx_data), exp_ctx.pop_front());
      ctx_wr_n++;
    end
    if (o_state_wea != '0) begin
      chk("st_ena", 256'(o_state_ena), 256'(4'hF));
      chk("st_wea", 256'(o_state_wea), 256'(4'hF));
      chk("st_addr", 256'(o_state_addra), 256'(st_wr_n));
      if (exp_wr.size() == 0) chk("st_unexpected", 256'(exp_wr.size()), 256'(1));
      else chk("st_data", o_state_dina, exp_wr.pop_front());
      st_wr_n++;
    end
    if (o_start) start_w++;
    else if (start_w != 0) begin
      chk("start_width", 256'(start_w), 256'(1));
      start_pulses++;
      start_w = 0;
    end
    if (stall_pend) begin
      chk("stall_valid", 256'(o_rd_valid), 256'(1));
      chk("stall_data", o_rd_data, stall_data);
    end
    stall_pend = o_rd_valid && !i_rd_ready;
    stall_data = o_rd_data;
    if (o_rd_valid && i_rd_ready) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", 256'(exp_rd.size()), 256'(1));
      else chk("rd_data", o_rd_data, exp_rd.pop_front());
      chk("rd_last", 256'(o_rd_last), 256'(rd_n == exp_words - 1));
      rd_n++;
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 256'({o_busy, o_done, o_err, o_ld_ready, o_rd_valid, o_rd_last, o_start,
                              o_ctx_en, o_ctx_wea, o_state_ena, o_state_wea, o_qbit_num,
                              o_exec_cycles, o_ctx_addr, o_state_addra}), 256'(0));
    chk({tag, "_rd_data"}, o_rd_data, 256'(0));
    chk({tag, "_ctx_data"}, 256'(o_ctx_data), 256'(0));
    chk({tag, "_dina"}, o_state_dina, 256'(0));
  endtask

  task automatic start_run(input int q, input int ins, input logic auto_i);
    ctx_wr_n = 0; st_wr_n = 0; rd_n = 0; start_pulses = 0;
    exp_ctx.delete(); exp_wr.delete(); exp_rd.delete();
    exp_words = (q <= 2) ? 1 : (1 << (q - 2));
    i_qbit_num = MAX_QBIT_WIDTH'(q);
    i_ins_num = INS_W'(ins);
    i_auto_init = auto_i;
    i_run = 1'b1;
    @(posedge clk); #1;
    i_run = 1'b0;
  endtask

  task automatic send_beat(input logic [255:0] d);
    int n = 0;
    i_ld_valid = 1'b1;
    i_ld_data = d;
    do begin @(negedge clk); n++; end while (!o_ld_ready && n < 200);
    if (!o_ld_ready) chk("ld_ready_timeout", 256'(o_ld_ready), 256'(1));
    @(posedge clk); #1;
    i_ld_valid = 1'b0;
  endtask

  task automatic send_ctx(input int n);
    logic [255:0] d;
    for (int i = 0; i < n; i++) begin
      d = rnd256();
      exp_ctx.push_back(256'(d[63:0]));
      send_beat(d);
    end
  endtask

  task automatic send_state(input int n);
    logic [255:0] d;
    for (int i = 0; i < n; i++) begin
      d = rnd256();
      if (i == 0) w0 = d;
      exp_wr.push_back(d);
      exp_rd.push_back(d);
      send_beat(d);
    end
  endtask

  task automatic wait_start();
    int n = 0;
    do begin @(negedge clk); n++; end while (!o_start && n < 5000);
    chk("start_seen", 256'(o_start), 256'(1));
  endtask

  task automatic read_all(input logic toggle);
    for (int c = 0; c < 20000 && !o_done; c++) begin
      @(posedge clk); #1;
      i_rd_ready = toggle ? ~i_rd_ready : 1'b1;
    end
    i_rd_ready = 1'b0;
    chk("read_done", 256'(o_done), 256'(1));
  endtask

  initial begin
    rst_n = 1'b0; i_run = 1'b0; i_abort = 1'b0; i_auto_init = 1'b0; i_ld_valid = 1'b0;
    i_rd_ready = 1'b0; i_complete = 1'b0; i_qbit_num = '0; i_ins_num = '0; i_ld_data = '0;
    ctx_wr_n = 0; st_wr_n = 0; rd_n = 0; start_w = 0; start_pulses = 0; exp_words = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Run A: 12 qubits, 167 ctx words, auto-init requested
    start_run(12, 167, 1'b1);
    chk("A_busy", 256'(o_busy), 256'(1));
    chk("A_qbit", 256'(o_qbit_num), 256'(12));
    send_ctx(167);
`ifdef QEA_AUTO_INIT_EN
    w0 = INIT_EXP;
    for (int i = 0; i < 1024; i++) begin
      exp_wr.push_back(i == 0 ? INIT_EXP : 256'(0));
      exp_rd.push_back(i == 0 ? INIT_EXP : 256'(0));
    end
`else
    send_state(1024);
`endif
    wait_start();
    chk("A_ctx_writes", 256'(ctx_wr_n), 256'(167));
    chk("A_state_writes", 256'(st_wr_n), 256'(1024));
    m0 = mem[0];
    chk("A_word0_msb", 256'(m0[255:192]), 256'(w0[255:192]));
    repeat (50) @(posedge clk);
    #1 i_complete = 1'b1;
    @(posedge clk); #1;
    i_complete = 1'b0;
    chk("A_exec_cycles", 256'(o_exec_cycles), 256'(50));
    read_all(1'b1);
    chk("A_rd_words", 256'(rd_n), 256'(1024));
    chk("A_rd_left", 256'(exp_rd.size()), 256'(0));
    chk("A_start_pulses", 256'(start_pulses), 256'(1));
    chk("A_busy_end", 256'(o_busy), 256'(0));

    // Run B: qubit count too large for the state RAM
    start_run(63, 5, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("B_err", 256'(o_err), 256'(1));
    chk("B_done", 256'(o_done), 256'(1));
    chk("B_no_writes", 256'(ctx_wr_n + st_wr_n), 256'(0));

    // Run C: abort during state load, then abort+run from IDLE
    start_run(4, 3, 1'b0);
    chk("C_err_cleared", 256'(o_err), 256'(0));
    send_ctx(3);
    send_state(2);
    i_abort = 1'b1; i_run = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0; i_run = 1'b0;
    chk("C_abort_state", 256'({o_busy, o_done, o_ld_ready, o_state_wea}), 256'(0));
    chk("C_writes", 256'(ctx_wr_n * 100 + st_wr_n), 256'(302));
    i_abort = 1'b1; i_run = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0; i_run = 1'b0;
    chk("C_abort_wins", 256'(o_busy), 256'(0));

    // Run D: reset asserted during RUN
    start_run(5, 2, 1'b0);
    send_ctx(2);
    send_state(8);
    wait_start();
    repeat (10) @(posedge clk);
    #1 chk("D_busy_run", 256'(o_busy), 256'(1));
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("D_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Run E: 2 qubits, no ctx words, single-word readback
    start_run(2, 0, 1'b0);
    send_state(1);
    wait_start();
    repeat (5) @(posedge clk);
    #1 i_complete = 1'b1;
    @(posedge clk); #1;
    i_complete = 1'b0;
    chk("E_exec_cycles", 256'(o_exec_cycles), 256'(5));
    read_all(1'b0);
    chk("E_rd_words", 256'(rd_n), 256'(1));
    chk("E_ctx_writes", 256'(ctx_wr_n), 256'(0));
    chk("E_state_writes", 256'(st_wr_n), 256'(1));
    chk("E_start_pulses", 256'(start_pulses), 256'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
